// File: rtl/eth_tx_sched_pkg.sv
// Shared types and defaults for the eth_tx_sched frame scheduler.
package eth_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TAIL,
        GAP
    } sched_state_t;

    localparam int ETH_MAX_FRAME = 1518;
    localparam int DEF_AW        = $clog2(ETH_MAX_FRAME + 1);
    localparam int DEF_IFG_CYC   = 960;

    function automatic int ptr_width(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/eth_rr_arb.sv
// Round-robin arbiter: one-hot winner searched from the registered pointer.
module eth_rr_arb
    import eth_tx_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr_nxt,
    input  logic            upd,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   ptr
);

    logic          found;
    logic [PW-1:0] idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (upd) begin
            ptr <= ptr_nxt;
        end
    end

    // First requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = PW'((int'(ptr) + off) % NREQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Shares one 10BASE-T transmitter among NREQ frame buffers, round-robin with an inter-frame gap.
// Optional watchdog abort enabled by defining ETH_TX_SCHED_WDT_EN.
module eth_tx_sched
    import eth_tx_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEF_AW,
    parameter int IFG_CYC = DEF_IFG_CYC,
    parameter int TO_CYC  = 2_000_000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] len,
    input  logic [NREQ*8-1:0]  rd_data,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      rd_addr,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic               busy,
    input  logic               mem_rd,
    input  logic               t_complete,
    output logic [7:0]         eth_in,
    output logic               b_end
);

    localparam int PW = ptr_width(NREQ);
    localparam int GW = $clog2(IFG_CYC + 1);

    if (NREQ < 2 || NREQ > 4 || IFG_CYC < 1 || TO_CYC < 1) begin : g_bad_param
        $error("eth_tx_sched: unsupported parameter set");
    end

    sched_state_t  state_q, state_d;
    logic [AW-1:0] flen;
    logic [GW-1:0] gap_cnt;
    logic [NREQ-1:0] win;
    logic [AW-1:0] win_len;
    logic [PW-1:0] ptr, ptr_nxt;
    logic          last, wdt_hit;
    logic          do_grant, do_inc, do_close, do_abort;

    eth_rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .ptr_nxt (ptr_nxt),
        .upd     (do_close | do_abort),
        .win     (win),
        .ptr     (ptr)
    );

    always_comb begin
        win_len = '0;
        ptr_nxt = '0;
        eth_in  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) win_len = len[i*AW +: AW];
            if (gnt[i]) begin
                eth_in  = rd_data[i*8 +: 8];
                ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign last  = (rd_addr == flen - AW'(1));
    assign busy  = (state_q != IDLE);
    assign b_end = (state_q == SEND || state_q == TAIL) && last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // t_complete outranks both the watchdog and a coincident mem_rd.
    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_inc   = 1'b0;
        do_close = 1'b0;
        do_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND, TAIL: begin
                if (t_complete) begin
                    do_close = 1'b1;
                    state_d  = GAP;
                end else if (wdt_hit) begin
                    do_abort = 1'b1;
                    state_d  = GAP;
                end else if (state_q == SEND && mem_rd) begin
                    if (last) begin
                        state_d = TAIL;
                    end else begin
                        do_inc = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt     <= '0;
            flen    <= AW'(1);
            rd_addr <= '0;
            gap_cnt <= '0;
            done    <= '0;
        end else begin
            done <= '0;
            if (do_grant) begin
                gnt     <= win;
                flen    <= (win_len == '0) ? AW'(1) : win_len;
                rd_addr <= '0;
            end
            if (do_inc) rd_addr <= rd_addr + 1'b1;
            if (do_close || do_abort) begin
                gnt     <= '0;
                gap_cnt <= GW'(IFG_CYC - 1);
            end
            if (do_close) done <= gnt;
            if (state_q == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end

`ifdef ETH_TX_SCHED_WDT_EN
    localparam int WW = $clog2(TO_CYC + 1);
    logic [WW-1:0] wdt_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wdt_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= do_abort;
            if (do_grant) begin
                wdt_cnt <= '0;
            end else if (state_q == SEND || state_q == TAIL) begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
        end
    end

    assign wdt_hit = (wdt_cnt == WW'(TO_CYC - 1));
`else
    assign wdt_hit = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_eth_tx_sched;

    localparam int NREQ    = 2;
    localparam int AW      = 11;
    localparam int IFG_CYC = 8;
    localparam int TO_CYC  = 50;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } byte_exp_t;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [7:0]      first;
        logic            last;
        bit              gap_chk;
    } gnt_exp_t;

    logic               clk;
    logic               resetn;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] len;
    logic [NREQ*8-1:0]  rd_data;
    logic [NREQ-1:0]    gnt;
    logic [AW-1:0]      rd_addr;
    logic [NREQ-1:0]    done;
    logic               err;
    logic               busy;
    logic               mem_rd;
    logic               t_complete;
    logic [7:0]         eth_in;
    logic               b_end;

    int n_checks = 0;
    int n_fail   = 0;

    byte_exp_t       byte_q[$];
    gnt_exp_t        gnt_q[$];
    logic [NREQ-1:0] done_q[$];
    int              err_q[$];

    // Buffer 0 holds 0x10+addr, buffer 1 holds 0xA0+addr.
    assign rd_data = {8'hA0 + rd_addr[7:0], 8'h10 + rd_addr[7:0]};

    eth_tx_sched #(
        .NREQ    (NREQ),
        .AW      (AW),
        .IFG_CYC (IFG_CYC),
        .TO_CYC  (TO_CYC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .len        (len),
        .rd_data    (rd_data),
        .gnt        (gnt),
        .rd_addr    (rd_addr),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .mem_rd     (mem_rd),
        .t_complete (t_complete),
        .eth_in     (eth_in),
        .b_end      (b_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input logic [AW-1:0] v);
        len[i*AW +: AW] = v;
    endtask

    task automatic push_gnt(input logic [NREQ-1:0] g, input logic [7:0] first,
                            input logic last, input bit gap_chk);
        gnt_exp_t e;
        e.g = g; e.first = first; e.last = last; e.gap_chk = gap_chk;
        gnt_q.push_back(e);
    endtask

    task automatic mem_rd_pulse(input logic [7:0] d, input logic l);
        byte_exp_t e;
        e.data = d; e.last = l;
        byte_q.push_back(e);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
    endtask

    task automatic send_tc(input logic [NREQ-1:0] exp_done);
        done_q.push_back(exp_done);
        t_complete = 1'b1;
        tick();
        t_complete = 1'b0;
    endtask

    task automatic wait_gnt(input string name);
        for (int i = 0; i < 100 && gnt == '0; i++) tick();
        check(name, 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && busy; i++) tick();
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"},     32'(gnt),     32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_b_end"},   32'(b_end),   32'd0);
        check({tag, "_eth_in"},  32'(eth_in),  32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, byte, done or err.
    int              since_done = 1000;
    int              since_gnt  = 0;
    logic [NREQ-1:0] gnt_prev   = '0;
    logic            tc_prev    = 1'b0;

    always @(negedge clk) begin
        byte_exp_t be;
        gnt_exp_t  ge;
        int        ee;
        if (done != '0) since_done = 0;
        else since_done++;
        if (gnt != '0 && gnt_prev == '0) since_gnt = 0;
        else since_gnt++;

        if (gnt != '0 && gnt_prev == '0) begin
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
                ge = gnt_q.pop_front();
                check("gnt_onehot",    32'(gnt),     32'(ge.g));
                check("gnt_first_byte", 32'(eth_in), 32'(ge.first));
                check("gnt_first_bend", 32'(b_end),  32'(ge.last));
                check("gnt_rd_addr",   32'(rd_addr), 32'd0);
                check("gnt_busy",      32'(busy),    32'd1);
                if (ge.gap_chk) check("gnt_gap", 32'(since_done), 32'(IFG_CYC + 1));
            end
        end

        if (mem_rd && gnt != '0) begin
            if (byte_q.size() == 0) begin
                check("byte_unexpected", 32'(eth_in), 32'hFFFF);
            end else begin
                be = byte_q.pop_front();
                check("byte_eth_in", 32'(eth_in), 32'(be.data));
                check("byte_b_end",  32'(b_end),  32'(be.last));
            end
        end

        if (done != '0) begin
            check("done_after_tc", 32'(tc_prev), 32'd1);
            if (done_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
            else check("done_value", 32'(done), 32'(done_q.pop_front()));
        end

        if (err) begin
            if (err_q.size() == 0) begin
                check("err_unexpected", 32'(err), 32'd0);
            end else begin
                ee = err_q.pop_front();
                check("err_cycles_after_gnt", 32'(since_gnt), 32'(ee));
            end
        end

        gnt_prev = gnt;
        tc_prev  = t_complete;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        resetn     = 1'b0;
        req        = '0;
        len        = '0;
        mem_rd     = 1'b0;
        t_complete = 1'b0;
        #2;
        check_reset_values("reset");
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        // t_complete while idle is ignored.
        t_complete = 1'b1;
        tick();
        t_complete = 1'b0;
        check("idle_tc_busy", 32'(busy), 32'd0);
        check("idle_tc_gnt",  32'(gnt),  32'd0);
        tick();

        // Single frame of 4 bytes from requester 0, plus one extra strobe in TAIL.
        set_len(0, 11'd4);
        req = 2'b01;
        push_gnt(2'b01, 8'h10, 1'b0, 1'b0);
        wait_gnt("single_grant");
        req = 2'b00;
        set_len(0, 11'd7);
        mem_rd_pulse(8'h10, 1'b0);
        mem_rd_pulse(8'h11, 1'b0);
        mem_rd_pulse(8'h12, 1'b0);
        mem_rd_pulse(8'h13, 1'b1);
        check("single_tail_addr", 32'(rd_addr), 32'd3);
        mem_rd_pulse(8'h13, 1'b1);
        check("tail_extra_rd_addr", 32'(rd_addr), 32'd3);
        send_tc(2'b01);
        check("gap_busy_start", 32'(busy), 32'd1);
        repeat (IFG_CYC - 1) tick();
        check("gap_busy_last", 32'(busy), 32'd1);
        tick();
        check("gap_busy_end", 32'(busy), 32'd0);

        // Zero length on requester 1 behaves as a single byte.
        set_len(1, 11'd0);
        req = 2'b10;
        push_gnt(2'b10, 8'hA0, 1'b1, 1'b0);
        wait_gnt("len0_grant");
        req = 2'b00;
        mem_rd_pulse(8'hA0, 1'b1);
        check("len0_rd_addr", 32'(rd_addr), 32'd0);
        send_tc(2'b10);
        wait_idle("len0_idle");

        // Round-robin with both requesting: 0, 1, 0.
        set_len(0, 11'd2);
        set_len(1, 11'd3);
        req = 2'b11;
        push_gnt(2'b01, 8'h10, 1'b0, 1'b0);
        wait_gnt("rr_grant_a");
        mem_rd_pulse(8'h10, 1'b0);
        mem_rd_pulse(8'h11, 1'b1);
        push_gnt(2'b10, 8'hA0, 1'b0, 1'b1);
        send_tc(2'b01);
        wait_gnt("rr_grant_b");
        mem_rd_pulse(8'hA0, 1'b0);
        mem_rd_pulse(8'hA1, 1'b0);
        mem_rd_pulse(8'hA2, 1'b1);
        push_gnt(2'b01, 8'h10, 1'b0, 1'b1);
        send_tc(2'b10);
        wait_gnt("rr_grant_c");
        req = 2'b00;
        mem_rd_pulse(8'h10, 1'b0);
        mem_rd_pulse(8'h11, 1'b1);
        send_tc(2'b01);
        wait_idle("rr_idle");

        // mem_rd and t_complete together at rd_addr 5 of an 8-byte frame.
        set_len(0, 11'd8);
        req = 2'b01;
        push_gnt(2'b01, 8'h10, 1'b0, 1'b0);
        wait_gnt("coll_grant");
        req = 2'b00;
        for (int i = 0; i < 5; i++) mem_rd_pulse(8'(8'h10 + i), 1'b0);
        check("coll_pre_addr", 32'(rd_addr), 32'd5);
        byte_q.push_back('{data: 8'h15, last: 1'b0});
        done_q.push_back(2'b01);
        mem_rd     = 1'b1;
        t_complete = 1'b1;
        tick();
        mem_rd     = 1'b0;
        t_complete = 1'b0;
        check("coll_rd_addr", 32'(rd_addr), 32'd5);
        check("coll_gnt",     32'(gnt),     32'd0);
        check("coll_busy",    32'(busy),    32'd1);
        wait_idle("coll_idle");

        // Asynchronous reset while sending at rd_addr 2.
        set_len(0, 11'd6);
        req = 2'b01;
        push_gnt(2'b01, 8'h10, 1'b0, 1'b0);
        wait_gnt("rst_grant");
        req = 2'b00;
        mem_rd_pulse(8'h10, 1'b0);
        mem_rd_pulse(8'h11, 1'b0);
        check("rst_pre_addr", 32'(rd_addr), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        resetn = 1'b1;
        set_len(1, 11'd1);
        req = 2'b10;
        push_gnt(2'b10, 8'hA0, 1'b1, 1'b0);
        wait_gnt("post_rst_grant");
        req = 2'b00;
        mem_rd_pulse(8'hA0, 1'b1);
        send_tc(2'b10);
        wait_idle("post_rst_idle");

        // Frame whose t_complete never arrives within the watchdog window.
        set_len(0, 11'd4);
        req = 2'b01;
        push_gnt(2'b01, 8'h10, 1'b0, 1'b0);
`ifdef ETH_TX_SCHED_WDT_EN
        err_q.push_back(TO_CYC);
        wait_gnt("wdt_grant");
        req = 2'b00;
        for (int i = 0; i < 2 * TO_CYC && gnt != '0; i++) tick();
        check("wdt_gnt_cleared", 32'(gnt),  32'd0);
        check("wdt_in_gap",      32'(busy), 32'd1);
        wait_idle("wdt_idle");
        set_len(1, 11'd1);
        req = 2'b11;
        push_gnt(2'b10, 8'hA0, 1'b1, 1'b0);
        wait_gnt("wdt_next_grant");
        req = 2'b00;
        mem_rd_pulse(8'hA0, 1'b1);
        send_tc(2'b10);
        wait_idle("wdt_final_idle");
`else
        wait_gnt("nowdt_grant");
        req = 2'b00;
        repeat (TO_CYC + 10) tick();
        check("nowdt_err",  32'(err), 32'd0);
        check("nowdt_gnt",  32'(gnt), 32'd1);
        send_tc(2'b01);
        wait_idle("nowdt_idle");
`endif

        repeat (3) tick();
        check("byte_q_empty", 32'(byte_q.size()), 32'd0);
        check("gnt_q_empty",  32'(gnt_q.size()),  32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);
        check("err_q_empty",  32'(err_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
